adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Shares one combinational adder instance between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes. Operands are captured on grant, the sum and flags are registered, and the result is held with the winner's id until the consumer accepts it. The block sits between the request-issuing engines and a single response consumer. Throughput is at most one operation per three cycles.

Parameters:
GOLOBAL_DATA_BUS_WIDTH, 32, operand and result width in bits.
NUM_REQ, 4, number of requesters; must be at least 2.
ID_W, $clog2(NUM_REQ), width of the requester id (derived, not overridable).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester grant; at most one bit is set (one-hot or zero).
req_a  in  NUM_REQ*W  flattened operand A; requester i uses bits [i*W +: W].
req_b  in  NUM_REQ*W  flattened operand B, same layout as req_a.
resp_valid  out  1  a result is held.
resp_ready  in  1  consumer accepts the result.
resp_id  out  ID_W  index of the requester that produced the result.
resp_sum  out  W  sum of the two operands, modulo 2^W.
resp_equalFlag  out  1  resp_sum == 0.
resp_lessFlag  out  1  resp_sum > 0 as unsigned, i.e. resp_sum != 0.
busy  out  1  the state machine is not in IDLE.
op_count  out  CNT_W  number of completed response handshakes; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n low) sets:
  - state = IDLE and rr_ptr = 0;
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_sum = 0;
  - resp_equalFlag = 0, resp_lessFlag = 0, busy = 0, op_count = 0.
- Reset mid-operation discards the captured operands and any pending result. No response is emitted for that operation.
- IDLE state:
  - If no req_valid bit is set: req_ready = 0 and the state stays IDLE.
  - Otherwise the winner is the first set bit found by searching indices rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[winner] is driven combinationally in the same cycle. The request/grant handshake completes in that cycle.
  - On that clock edge: opA <= req_a[winner], opB <= req_b[winner], id <= winner, rr_ptr <= (winner+1) mod NUM_REQ. Next state is CALC.
- CALC state:
  - req_ready = 0.
  - The adder sub-module sums opA and opB. resp_sum, resp_equalFlag, resp_lessFlag and resp_id are registered from it, and resp_valid <= 1.
  - Next state is RESP.
- RESP state:
  - resp_valid = 1 and all resp_* outputs are held stable.
  - On resp_valid && resp_ready: resp_valid <= 0, op_count increments (saturating), and next state is IDLE.
  - With no handshake, the state stays RESP indefinitely.
- No new grant is issued in RESP or CALC. The earliest next grant is the cycle after the response handshake.
- Latency: grant in cycle T, resp_valid is high in T+2, earliest acceptance in T+2, next grant in T+3.
- Requesters must hold req_valid and their operands until they see req_ready. Withdrawing req_valid before grant is legal; the request is simply not considered.
- The carry-out is dropped. Example: 0xFFFFFFFF + 1 gives resp_sum = 0, resp_equalFlag = 1, resp_lessFlag = 0.
- Exactly one of the two flags is 1 for any registered result.
- busy = (state != IDLE), registered from the state.
- Operand bits belonging to non-winning requesters have no effect.

Decomposition:
- Package adder_arb_pkg holds:
  - the state enum (IDLE, CALC, RESP), 2-bit, encoded 0/1/2;
  - default widths;
  - the round-robin search function rr_pick(valid, ptr), which returns winner index and found flag.
- One sub-module, the existing adder block with GOLOBAL_DATA_BUS_WIDTH passed through, is instantiated once on opA/opB. Its flag outputs feed the response registers directly.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, all req_valid = 0. All outputs stay 0, busy = 0 and no req_ready is asserted.
- Single request: req_valid = 4'b0010, a = 5, b = 7. req_ready = 4'b0010 in the grant cycle. Two cycles later resp_valid = 1 with resp_id = 1, resp_sum = 12, equalFlag = 0, lessFlag = 1. op_count = 1 after acceptance.
- Round-robin fairness: all four requesters held valid continuously with resp_ready = 1. Grants occur in order 0, 1, 2, 3, 0, spaced 3 cycles apart.
- Wrap and zero flags:
  - 0xFFFFFFFF + 0x00000001 gives sum 0, equalFlag = 1, lessFlag = 0.
  - 0 + 0 gives the same result.
- Backpressure: resp_ready = 0 for 10 cycles with other requesters valid. resp_* outputs are stable, no req_ready is asserted, and busy = 1. When resp_ready rises, the handshake completes and the next grant follows one cycle later.
- Reset mid-operation: assert rst_n low during CALC. resp_valid never rises for that operation, rr_ptr returns to 0, and the next grant favours requester 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types, default widths and the round-robin search helper for the
// adder-sharing arbiter.
package adder_arb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 16;

  // Upper bound on the requester count that rr_pick can search.
  localparam int MAX_REQ     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], searching ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int unsigned        ptr,
                                       input int unsigned        n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n && !r.found) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = 8'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// Plain combinational adder with zero / non-zero flags. Carry-out is dropped.
module adder_share_arbiter_adder
  import adder_arb_pkg::*;
#(
  parameter int GOLOBAL_DATA_BUS_WIDTH = DEF_DATA_W
) (
  input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] a,
  input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] b,
  output logic [GOLOBAL_DATA_BUS_WIDTH-1:0] sum,
  output logic                              equal_flag,
  output logic                              less_flag
);

  // Sum modulo 2^W; exactly one of the two flags is set for any sum.
  always_comb begin
    sum        = a + b;
    equal_flag = (sum == '0);
    less_flag  = (sum != '0);
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters.
// IDLE grants and captures operands, CALC registers the sum, RESP holds the
// result until the consumer accepts it.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int GOLOBAL_DATA_BUS_WIDTH = DEF_DATA_W,
  parameter  int NUM_REQ                = DEF_NUM_REQ,
  parameter  int CNT_W                  = DEF_CNT_W,
  localparam int ID_W                   = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ*GOLOBAL_DATA_BUS_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*GOLOBAL_DATA_BUS_WIDTH-1:0] req_b,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [ID_W-1:0]                           resp_id,
  output logic [GOLOBAL_DATA_BUS_WIDTH-1:0]         resp_sum,
  output logic                                      resp_equalFlag,
  output logic                                      resp_lessFlag,
  output logic                                      busy,
  output logic [CNT_W-1:0]                          op_count
);

  localparam int W = GOLOBAL_DATA_BUS_WIDTH;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      op_id;
  logic [W-1:0]         op_a;
  logic [W-1:0]         op_b;

  logic [MAX_REQ-1:0]   valid_ext;
  rr_pick_t             pick;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      next_ptr;
  logic                 grant;

  logic [W-1:0]         add_sum;
  logic                 add_eq;
  logic                 add_lt;

  // Round-robin winner search and combinational grant while IDLE.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
    pick                   = rr_pick(valid_ext, int'(rr_ptr), NUM_REQ);
    win_id                 = ID_W'(pick.idx);
    grant                  = (state == IDLE) && pick.found;
    req_ready              = grant ? (NUM_REQ'(1) << win_id) : '0;
    next_ptr               = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  end

  // Operand capture on grant; contents only matter once CALC is reached.
  // NOTE: pure datapath registers carry no reset; the FSM guards their use.
  always_ff @(posedge clk) begin
    if (grant) begin
      op_a  <= req_a[win_id*W +: W];
      op_b  <= req_b[win_id*W +: W];
      op_id <= win_id;
    end
  end

  adder_share_arbiter_adder #(
    .GOLOBAL_DATA_BUS_WIDTH(W)
  ) u_adder (
    .a         (op_a),
    .b         (op_b),
    .sum       (add_sum),
    .equal_flag(add_eq),
    .less_flag (add_lt)
  );

  // Control FSM, response registers and saturating completion counter.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_sum       <= '0;
      resp_equalFlag <= 1'b0;
      resp_lessFlag  <= 1'b0;
      op_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            rr_ptr <= next_ptr;
            state  <= CALC;
          end
        end
        CALC: begin
          resp_sum       <= add_sum;
          resp_equalFlag <= add_eq;
          resp_lessFlag  <= add_lt;
          resp_id        <= op_id;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            if (op_count != '1) op_count <= op_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy is a decode of the registered state.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomised transaction-level bench for adder_share_arbiter with a
// behavioural model of the round-robin order, sum and flags.
module tb_adder_share_arbiter;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [W-1:0]     resp_sum;
  logic             resp_equalFlag;
  logic             resp_lessFlag;
  logic             busy;
  logic [CW-1:0]    op_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  adder_share_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_sum      (resp_sum),
    .resp_equalFlag(resp_equalFlag),
    .resp_lessFlag (resp_lessFlag),
    .busy          (busy),
    .op_count      (op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_winner(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic scramble_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rv"},   resp_valid, 0);
    check({tag, "_rdy"},  req_ready, 0);
    check({tag, "_id"},   resp_id, 0);
    check({tag, "_sum"},  resp_sum, 0);
    check({tag, "_eq"},   resp_equalFlag, 0);
    check({tag, "_lt"},   resp_lessFlag, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt"},  op_count, 0);
  endtask

  // One request cycle (or idle cycle if mask is empty) followed by the full
  // CALC/RESP sequence, holding resp_ready low for `hold` RESP cycles.
  task automatic run_txn(input logic [N-1:0] mask, input bit fixed,
                         input logic [W-1:0] fa, input logic [W-1:0] fb,
                         input int hold);
    int           win;
    logic [W-1:0] wa, wb, esum;
    logic [W:0]   full;
    logic [N-1:0] eready;
    scramble_operands();
    win = model_winner(mask, m_ptr);
    if (win < 0) begin
      req_valid = mask;
      #1;
      check("idle_no_grant", req_ready, 0);
      check("idle_busy", busy, 0);
      step();
    end else begin
      if (fixed) begin
        req_a[win*W +: W] = fa;
        req_b[win*W +: W] = fb;
      end
      wa = req_a[win*W +: W];
      wb = req_b[win*W +: W];
      req_valid = mask;
      #1;
      eready = '0;
      eready[win] = 1'b1;
      check("grant", req_ready, eready);
      check("grant_busy", busy, 0);
      check("grant_rv", resp_valid, 0);
      step();
      m_ptr = (win + 1) % N;
      // Winner withdraws; everyone else keeps making noise on the bus.
      req_valid = N'($urandom) & ~eready;
      scramble_operands();
      #1;
      check("calc_rdy", req_ready, 0);
      check("calc_rv", resp_valid, 0);
      check("calc_busy", busy, 1);
      step();
      full = {1'b0, wa} + {1'b0, wb};
      esum = full[W-1:0];
      for (int h = 0; h <= hold; h++) begin
        resp_ready = (h == hold);
        #1;
        check("resp_rv", resp_valid, 1);
        check("resp_id", resp_id, 64'(win));
        check("resp_sum", resp_sum, esum);
        check("resp_eq", resp_equalFlag, (esum == 0));
        check("resp_lt", resp_lessFlag, (esum != 0));
        check("resp_busy", busy, 1);
        check("resp_rdy", req_ready, 0);
        step();
      end
      if (m_count < (1 << CW) - 1) m_count++;
      resp_ready = 1'b0;
      req_valid  = '0;
      #1;
      check("post_rv", resp_valid, 0);
      check("post_busy", busy, 0);
      check("post_cnt", op_count, 64'(m_count));
    end
  endtask

  initial begin
    int win;
    logic [N-1:0] eready;

    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;

    // Reset then idle.
    repeat (3) begin
      step();
      check_all_zero("rst");
    end
    rst_n = 1'b1;
    repeat (2) begin
      step();
      check_all_zero("idle");
    end

    // Single request from requester 1.
    run_txn(4'b0010, 1'b1, 32'd5, 32'd7, 0);

    // Wrap to zero, then zero plus zero.
    run_txn(4'b1000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_txn(4'b0001, 1'b1, 32'h0, 32'h0, 0);

    // Backpressure with other requesters active.
    run_txn(4'b0110, 1'b0, 32'h0, 32'h0, 10);

    // Reset while in CALC: no response, pointer back to 0.
    scramble_operands();
    req_valid = 4'b1111;
    win = model_winner(4'b1111, m_ptr);
    #1;
    eready = '0;
    eready[win] = 1'b1;
    check("mid_grant", req_ready, eready);
    step();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_rv", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    step();
    check("mid_rst_rv2", resp_valid, 0);
    rst_n   = 1'b1;
    m_ptr   = 0;
    m_count = 0;
    step();
    check("mid_after_rv", resp_valid, 0);
    check("mid_after_cnt", op_count, 0);

    // Round-robin with all requesters valid: 0, 1, 2, 3, 0.
    repeat (5) run_txn(4'b1111, 1'b0, 32'h0, 32'h0, 0);

    // Randomised traffic.
    repeat (150) run_txn(N'($urandom), 1'b0, 32'h0, 32'h0, int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
